// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, writeback request type and grant encoding
package core_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  // One pending register-file write: destination and value.
  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

  // Which source won the most recent arbitration.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry holding slot for a single writeback source
module wb_slot
  import core_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    slot_valid,
  output wb_req_t slot_req
);

  logic    valid_d, valid_q;
  wb_req_t req_d, req_q;

  // The slot can accept when empty or when it drains this cycle, giving one result per cycle.
  assign in_ready   = !valid_q || grant;
  assign slot_valid = valid_q;
  assign slot_req   = req_q;

  // Load on transfer (a refill wins over the drain), otherwise clear when granted.
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      req_d   = in_req;
    end else if (grant) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register; reset discards any held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - ALU/LSU writeback arbiter with registered RF write port (optional WB_BYPASS_EN forwarding)
module writeback_unit
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              we,
  output logic [REG_AW-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rd_addr_0,
  input  logic [REG_AW-1:0] rd_addr_1,
  input  logic [XLEN-1:0]   rf_rd_data_0,
  input  logic [XLEN-1:0]   rf_rd_data_1,
  output logic [XLEN-1:0]   rd_data_0,
  output logic [XLEN-1:0]   rd_data_1,
  output logic              busy
);

  logic    alu_slot_valid, lsu_slot_valid;
  wb_req_t alu_slot_req, lsu_slot_req;
  wb_req_t alu_in_req, lsu_in_req;
  logic    grant_alu, grant_lsu;

  logic      we_d, we_q;
  reg_addr_t wr_addr_d, wr_addr_q;
  xlen_t     wr_data_d, wr_data_q;
  grant_e    last_grant_d, last_grant_q;

  assign alu_in_req = '{rd: alu_rd, data: alu_data};
  assign lsu_in_req = '{rd: lsu_rd, data: lsu_data};

  wb_slot u_alu_slot (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (alu_valid),
    .in_ready   (alu_ready),
    .in_req     (alu_in_req),
    .grant      (grant_alu),
    .slot_valid (alu_slot_valid),
    .slot_req   (alu_slot_req)
  );

  wb_slot u_lsu_slot (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (lsu_valid),
    .in_ready   (lsu_ready),
    .in_req     (lsu_in_req),
    .grant      (grant_lsu),
    .slot_valid (lsu_slot_valid),
    .slot_req   (lsu_slot_req)
  );

  // Round-robin between the two slots: on contention the source not granted last wins.
  always_comb begin
    grant_alu = alu_slot_valid && (!lsu_slot_valid || (last_grant_q == GRANT_LSU));
    grant_lsu = lsu_slot_valid && !grant_alu;
  end

  // Next write-port values: x0 targets are drained without raising we; idle cycles hold addr/data.
  always_comb begin
    we_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (grant_alu) begin
      we_d         = (alu_slot_req.rd != '0);
      wr_addr_d    = alu_slot_req.rd;
      wr_data_d    = alu_slot_req.data;
      last_grant_d = GRANT_ALU;
    end else if (grant_lsu) begin
      we_d         = (lsu_slot_req.rd != '0);
      wr_addr_d    = lsu_slot_req.rd;
      wr_data_d    = lsu_slot_req.data;
      last_grant_d = GRANT_LSU;
    end
  end

  // Registered write port; last_grant resets to LSU so the ALU wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= GRANT_LSU;
    end else begin
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign we      = we_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = alu_slot_valid || lsu_slot_valid || we_q;

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to decode; x0 is never forwarded.
  always_comb begin
    rd_data_0 = rf_rd_data_0;
    rd_data_1 = rf_rd_data_1;
    if (we_q && (wr_addr_q == rd_addr_0) && (rd_addr_0 != '0)) rd_data_0 = wr_data_q;
    if (we_q && (wr_addr_q == rd_addr_1) && (rd_addr_1 != '0)) rd_data_1 = wr_data_q;
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr_0, rd_addr_1};

  // No forwarding: decode sees register-file data and resolves hazards itself.
  always_comb begin
    rd_data_0 = rf_rd_data_0;
    rd_data_1 = rf_rd_data_1;
  end
`endif

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have no parameters; widths come from the shared package: XLEN = 64, register-address width = 5.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid / alu_ready  input / output  1 / 1  ALU result handshake.
REQ-005 alu_rd / alu_data  input  5 / 64  ALU destination register and result.
REQ-006 lsu_valid / lsu_ready  input / output  1 / 1  load-unit result handshake.
REQ-007 lsu_rd / lsu_data  input  5 / 64  load destination register and data.
REQ-008 we / wr_addr / wr_data  output  1 / 5 / 64  register-file write port, all registered.
REQ-009 rd_addr_0, rd_addr_1  input  5 each  decode read addresses, also driven to the register file.
REQ-010 rf_rd_data_0, rf_rd_data_1  input  64 each  register-file read data.
REQ-011 rd_data_0, rd_data_1  output  64 each  operand data delivered to decode.
REQ-012 busy  output  1  high while any holding slot is valid or we is high.

Function
REQ-013 Each source SHALL own a one-entry holding slot (valid, rd, data).
- A transfer occurs when valid && ready.
- src_ready = !slot_valid || slot granted this cycle (back-to-back 1/cycle).
REQ-014 The arbiter SHALL grant exactly one valid slot per cycle:
- Single valid slot: that slot is granted.
- Both valid: grant goes to the source not granted last, tracked by last_grant; after reset the ALU wins first.
REQ-015 On a grant, at the next edge: we = (slot_rd != 0), wr_addr = slot_rd, wr_data = slot_data, slot cleared.
- A same-edge new transfer refills the slot.
REQ-016 With no grant, at the next edge: we = 0; wr_addr and wr_data hold their values.
REQ-017 Latency SHALL be fixed.
- Transfer at edge N, slot uncontended: we high in cycle N+1 to N+2.
- Register file commits at edge N+2.
REQ-018 Writes to x0 SHALL be consumed (slot freed, ready returned) with we = 0.
REQ-019 Both slots targeting the same rd SHALL write in grant order; the last grant's data persists.
REQ-020 Slot data SHALL never be dropped or duplicated while rst is high.

Reset
REQ-021 On rst low, immediately and independent of clk:
- both slots invalid; we = 0, wr_addr = 0, wr_data = 0; last_grant = LSU; busy = 0.
- alu_ready = lsu_ready = 1 once slots are clear.
REQ-022 Reset mid-operation SHALL discard held results; no write issues for them after rst rises.

Configuration
REQ-023 Macro WB_BYPASS_EN SHALL select operand forwarding.
- Defined: rd_data_k = wr_data when we && wr_addr == rd_addr_k && rd_addr_k != 0, else rf_rd_data_k.
- Undefined: rd_data_k = rf_rd_data_k, and decode stalls on hazards itself.

Structure
REQ-024 The shared package core_pkg SHALL hold:
- XLEN; reg_addr_t (5-bit); xlen_t (64-bit);
- a wb_req_t struct {rd, data}; the GRANT_ALU / GRANT_LSU encoding.
REQ-025 The holding slot SHALL be the sub-module wb_slot, instantiated twice; arbitration and the output register stay in writeback_unit.

Verification
REQ-026 Single ALU result:
- Stimulus: alu rd = 5, data = 0xDEAD_BEEF accepted at edge 0.
- Response: we = 1, wr_addr = 5 in cycle 1 to 2; busy = 0 after edge 2.
REQ-027 Simultaneous results:
- Stimulus: ALU (rd 3, 0x11) and LSU (rd 4, 0x22) accepted at the same edge after reset.
- Response: ALU writes first, LSU next cycle; lsu_ready low for exactly one cycle.
REQ-028 x0 suppression:
- Stimulus: lsu rd = 0, data = 0xFFFF.
- Response: we stays 0, lsu_ready returns to 1, no register changes.
REQ-029 Fairness:
- Stimulus: both sources hold valid for 8 cycles.
- Response: grants alternate ALU, LSU, ALU, ...; four writes each; same-rd case ends with the last-granted value.
REQ-030 Async reset:
- Stimulus: rst low mid-cycle with both slots full.
- Response: we = 0 immediately, no write after release, both ready = 1.
REQ-031 Bypass:
- Stimulus: WB_BYPASS_EN defined; we = 1, wr_addr = 7, wr_data = 0x42, rd_addr_0 = 7.
- Response: rd_data_0 = 0x42 with WB_BYPASS_EN defined; equals rf_rd_data_0 with it undefined.
- x0 check: rd_addr_0 = 0 never forwards.
